// File: rtl/reg_file.sv
// RISC-V integer register file: 32 x 32-bit entries with x0 hardwired to zero.
// Two decode read ports with write-first bypass, plus one debug read port that shows stored contents only.
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] ra1,
    input  logic [ADDR_WIDTH-1:0] ra2,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2,
    input  logic [ADDR_WIDTH-1:0] wa,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] ra_dbg,
    output logic [DATA_WIDTH-1:0] rd_dbg
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic                  wr_en_d;

    // A write commits only when it targets a real register and reset is idle.
    always_comb begin
        wr_en_d = 1'b0;
        if (we && !rst && (wa != {ADDR_WIDTH{1'b0}})) begin
            wr_en_d = 1'b1;
        end else begin
            wr_en_d = 1'b0;
        end
    end

    // Storage update: reset clears every entry and has priority over a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (wr_en_d) begin
            regs_q[wa] <= wd;
        end
    end

    // Port 1: x0 reads zero, otherwise the in-flight write wins over storage.
    always_comb begin
        rd1 = {DATA_WIDTH{1'b0}};
        if (ra1 == {ADDR_WIDTH{1'b0}}) begin
            rd1 = {DATA_WIDTH{1'b0}};
        end else if (wr_en_d && (ra1 == wa)) begin
            rd1 = wd;
        end else begin
            rd1 = regs_q[ra1];
        end
    end

    // Port 2: same bypass rule as port 1.
    always_comb begin
        rd2 = {DATA_WIDTH{1'b0}};
        if (ra2 == {ADDR_WIDTH{1'b0}}) begin
            rd2 = {DATA_WIDTH{1'b0}};
        end else if (wr_en_d && (ra2 == wa)) begin
            rd2 = wd;
        end else begin
            rd2 = regs_q[ra2];
        end
    end

    // Debug port deliberately skips the bypass so it reflects committed state.
    always_comb begin
        rd_dbg = {DATA_WIDTH{1'b0}};
        if (ra_dbg == {ADDR_WIDTH{1'b0}}) begin
            rd_dbg = {DATA_WIDTH{1'b0}};
        end else begin
            rd_dbg = regs_q[ra_dbg];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios followed by random traffic
// compared against a plain array model of the register file.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        we;
    logic [4:0]  ra_dbg;
    logic [31:0] rd_dbg;

    int          checks;
    int          failures;
    logic [31:0] model [32];

    reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .ra1    (ra1),
        .ra2    (ra2),
        .rd1    (rd1),
        .rd2    (rd2),
        .wa     (wa),
        .wd     (wd),
        .we     (we),
        .ra_dbg (ra_dbg),
        .rd_dbg (rd_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected read value; bypass selects the decode-port behaviour.
    function automatic logic [31:0] expect_rd(input logic [4:0] ra, input bit bypass);
        if (ra == 5'd0) return 32'h0000_0000;
        if (bypass && !rst && we && (wa != 5'd0) && (ra == wa)) return wd;
        return model[ra];
    endfunction

    // One rising edge; the model commits what the inputs request, then settle.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0000_0000;
        end else if (we && (wa != 5'd0)) begin
            model[wa] = wd;
        end
        #1;
    endtask

    task automatic check_ports(input string tag);
        check({tag, "_rd1"},    rd1,    expect_rd(ra1, 1'b1));
        check({tag, "_rd2"},    rd2,    expect_rd(ra2, 1'b1));
        check({tag, "_rd_dbg"}, rd_dbg, expect_rd(ra_dbg, 1'b0));
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0000_0000;
        rst = 1'b1; we = 1'b0; wa = 5'd0; wd = 32'h0000_0000;
        ra1 = 5'd0; ra2 = 5'd0; ra_dbg = 5'd0;
        #2;
        tick();
        rst = 1'b0;

        // Reset state on several addresses
        ra1 = 5'd5; ra2 = 5'd31; ra_dbg = 5'd17; #1;
        check("reset_rd1", rd1, 32'h0000_0000);
        check("reset_rd2", rd2, 32'h0000_0000);
        check("reset_dbg", rd_dbg, 32'h0000_0000);

        // Write to x0 is ignored
        we = 1'b1; wa = 5'd0; wd = 32'h0000_1145; ra1 = 5'd0; #1;
        check("x0_pre", rd1, 32'h0000_0000);
        tick();
        we = 1'b0; ra_dbg = 5'd0; #1;
        check("x0_post", rd1, 32'h0000_0000);
        check("x0_dbg", rd_dbg, 32'h0000_0000);

        // Basic write then read on all ports
        we = 1'b1; wa = 5'd1; wd = 32'h0000_1919;
        tick();
        we = 1'b0; ra1 = 5'd1; ra2 = 5'd1; ra_dbg = 5'd1; #1;
        check("wr_rd1", rd1, 32'h0000_1919);
        check("wr_rd2", rd2, 32'h0000_1919);
        check("wr_dbg", rd_dbg, 32'h0000_1919);

        // Bypass before the edge; debug port shows stored value
        ra2 = 5'd2; ra_dbg = 5'd2; #1;
        check("byp_idle", rd2, 32'h0000_0000);
        we = 1'b1; wa = 5'd2; wd = 32'h0011_4514; #1;
        check("byp_rd2", rd2, 32'h0011_4514);
        check("byp_dbg_old", rd_dbg, 32'h0000_0000);
        check("byp_rd1_other", rd1, 32'h0000_1919);
        tick();
        we = 1'b0; #1;
        check("byp_rd2_post", rd2, 32'h0011_4514);
        check("byp_dbg_post", rd_dbg, 32'h0011_4514);

        // Write disabled over several edges
        we = 1'b0; wa = 5'd3; wd = 32'hDEAD_BEEF; ra1 = 5'd3;
        tick(); tick(); tick();
        check("wdis_rd1", rd1, 32'h0000_0000);

        // Reset takes priority over a simultaneous write, no bypass under reset
        rst = 1'b1; we = 1'b1; wa = 5'd5; wd = 32'hFFFF_FFFF; ra1 = 5'd5; #1;
        check("rstpri_nobyp", rd1, 32'h0000_0000);
        tick();
        rst = 1'b0; we = 1'b0;
        ra1 = 5'd1; ra2 = 5'd2; ra_dbg = 5'd5; #1;
        check("rstclr_x1", rd1, 32'h0000_0000);
        check("rstclr_x2", rd2, 32'h0000_0000);
        check("rstclr_x5", rd_dbg, 32'h0000_0000);

        // Full sweep: reg[i] = i * 0x01010101
        for (int i = 0; i < 32; i++) begin
            we = 1'b1; wa = 5'(i); wd = 32'(i) * 32'h0101_0101;
            tick();
        end
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            logic [31:0] want;
            want = (i == 0) ? 32'h0000_0000 : 32'(i) * 32'h0101_0101;
            ra1 = 5'(i); ra2 = 5'(31 - i); ra_dbg = 5'(i); #1;
            check("sweep_rd1", rd1, want);
            check("sweep_dbg", rd_dbg, want);
            check("sweep_rd2", rd2, (i == 31) ? 32'h0000_0000 : 32'(31 - i) * 32'h0101_0101);
        end

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst    = ($urandom_range(0, 49) == 0);
            we     = $urandom_range(0, 2) != 0;
            wa     = 5'($urandom_range(0, 31));
            wd     = $urandom;
            ra1    = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ra2    = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ra_dbg = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            #1;
            check_ports("rand_pre");
            tick();
        end
        rst = 1'b0; we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(i); ra_dbg = 5'(i); #1;
            check_ports("rand_final");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
